// File: rtl/cpu32_div_pkg.sv
// Shared definitions for the sequential divider and the pipeline stall logic.
package cpu32_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ABSA,
    ABSB,
    RUN,
    NEGQ,
    NEGR
  } div_state_e;

  localparam int DIV_ITERS   = 32;
  localparam int DIV_LATENCY = 37;
  localparam int DIV_CNT_W   = $clog2(DIV_ITERS);

endpackage

// File: rtl/adder32.sv
// 32-bit add/subtract datapath: sub=1 computes a - b as a + ~b + 1.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] sum,
  output logic        carry_out,
  output logic        overflow
);

  logic [31:0] bx;
  logic [32:0] full;

  always_comb begin
    bx        = sub ? ~b : b;
    full      = {1'b0, a} + {1'b0, bx} + {32'd0, sub};
    sum       = full[31:0];
    carry_out = full[32];
    // Signed overflow: same-sign operands giving a result of the other sign.
    overflow  = (a[31] == bx[31]) & (sum[31] != a[31]);
  end

endmodule

// File: rtl/div32_seq.sv
// Fixed-latency signed/unsigned 32-bit restoring divider that time-shares one adder32
// across abs-value, iteration and sign fix-up steps.
module div32_seq
  import cpu32_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero
);

  div_state_e           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [XLEN-1:0]      r, q, d;
  logic                 sgn, a_neg, b_neg, d_zero;

  logic [XLEN-1:0]      add_a, add_b, sum, shifted;
  logic                 add_sub, carry, accept, nq, nr;
  logic                 unused_ovf;

  adder32 u_add (
    .a         (add_a),
    .b         (add_b),
    .sub       (add_sub),
    .sum       (sum),
    .carry_out (carry),
    .overflow  (unused_ovf)
  );

  assign shifted = {r[XLEN-2:0], q[XLEN-1]};
  // R[31] set means the shifted partial remainder exceeds 32 bits, so it always covers D.
  assign accept  = r[XLEN-1] | carry;
  assign nq      = sgn & (a_neg ^ b_neg) & ~d_zero;
  assign nr      = sgn & a_neg;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    unique case (state)
      ABSA: begin add_b = q; add_sub = sgn & a_neg; end
      ABSB: begin add_b = d; add_sub = sgn & b_neg; end
      RUN:  begin add_a = shifted; add_b = d; add_sub = 1'b1; end
      NEGQ: begin add_b = q; add_sub = nq; end
      NEGR: begin add_b = r; add_sub = nr; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      sgn         <= 1'b0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      d_zero      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          q      <= dividend;
          d      <= divisor;
          sgn    <= signed_op;
          a_neg  <= dividend[XLEN-1];
          b_neg  <= divisor[XLEN-1];
          d_zero <= (divisor == '0);
          busy   <= 1'b1;
          state  <= ABSA;
        end
        ABSA: begin
          q     <= sum;
          state <= ABSB;
        end
        ABSB: begin
          d     <= sum;
          r     <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          r   <= accept ? sum : shifted;
          q   <= {q[XLEN-2:0], accept};
          cnt <= cnt + 1'b1;
          if (cnt == DIV_CNT_W'(DIV_ITERS - 1)) state <= NEGQ;
        end
        NEGQ: begin
          quotient <= sum;
          state    <= NEGR;
        end
        NEGR: begin
          remainder   <= sum;
          div_by_zero <= d_zero;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div32_seq.md
# div32_seq

Multi-cycle 32-bit integer divider controller for the CPU execute stage. It sequences the team's existing `adder32` add/subtract datapath through operand absolute-value, 32 restoring-division iterations and sign fix-up, reusing the single adder every cycle. It serves DIV/DIVU/REM/REMU with a start/busy/done handshake and a fixed latency, so the pipeline stall logic is trivial.

## Interface
Parameters:
- `XLEN`, 32: operand width. Only 32 is supported; this matches `adder32`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; accepted only in IDLE
- `signed_op`  in  1  1 = signed (DIV/REM), 0 = unsigned; sampled at accept
- `dividend`  in  32  sampled at accept
- `divisor`  in  32  sampled at accept
- `busy`  out  1  high from the cycle after accept until the done cycle
- `done`  out  1  one-cycle pulse when results become valid
- `quotient`  out  32  registered; held until the next accept
- `remainder`  out  32  registered; held until the next accept
- `div_by_zero`  out  1  registered; set with `done` when the captured divisor is 0

## Operation
- States: IDLE, ABSA, ABSB, RUN, NEGQ, NEGR. Every operation traverses all of them, so latency is fixed.
- IDLE: `start`=1 captures operands and `signed_op`, then moves to ABSA.
- ABSA: adder A=0, B=dividend, sub=(signed_op & dividend[31]). This yields |dividend| or the dividend unchanged; the result is loaded into the quotient shift register Q.
- ABSB: the same operation on the divisor, loaded into register D.
- RUN: 32 iterations with iteration counter 0..31, R initialised to 0.
  - Per iteration, msb=R[31]; shifted={R[30:0],Q[31]}.
  - adder A=shifted, B=D, sub=1.
  - accept = msb | CARRY_OUT.
  - If accepted, R←SUM; otherwise R←shifted.
  - Q←{Q[30:0],accept}.
- NEGQ: adder A=0, B=Q, sub=nq, with nq = signed_op & (dividend[31]^divisor[31]) & (divisor≠0). The result goes to `quotient`.
- NEGR: adder A=0, B=R, sub=nr, with nr = signed_op & dividend[31]. The result goes to `remainder`. Also set `div_by_zero`=(divisor==0) and `done`←1, then return to IDLE.
- Divide by zero needs no special datapath; it falls out of the algorithm plus the nq mask:
  - quotient = 0xFFFFFFFF
  - remainder = original dividend (signed and unsigned)
- Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no flag.
- `adder32` OVERFLOW is unused. All adder inputs are muxed by state; in IDLE the adder inputs are don't-care.

## Timing
- Cycle 0: `start` high in IDLE and sampled at the edge.
- Cycle 1: ABSA. Cycle 2: ABSB. Cycles 3–34: RUN. Cycle 35: NEGQ. Cycle 36: NEGR.
- Cycle 37: `done`=1, `busy`=0, results valid. Total latency: 37 cycles, start to done.
- `busy`=1 in cycles 1–36 only.
- `start` while busy is ignored, with no queuing. Input changes during busy have no effect.
- `start` in the done cycle is accepted, because the state is IDLE. That gives back-to-back throughput of one operation per 37 cycles.
- `quotient`, `remainder` and `div_by_zero` change only at the NEGQ and NEGR edges. They stay stable from the done cycle until the next operation's NEGQ.
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, counter 0.
- `rst` mid-operation: the next cycle is IDLE with the outputs above. No `done` is issued for the aborted operation.
- `rst` and `start` in the same cycle: `rst` wins and the start is dropped.

## Structure
- Shared package `cpu32_div_pkg` holds:
  - the state enum (IDLE, ABSA, ABSB, RUN, NEGQ, NEGR);
  - `DIV_ITERS`=32;
  - `DIV_LATENCY`=37, used by the pipeline stall logic.
- Exactly one sub-module: `adder32`, instantiated once and shared by all states. No other adder or subtractor is permitted.
- Remaining logic: state register, 5-bit iteration counter, registers R, Q and D, captured sign bits, and the output registers.

## Test plan
- Unsigned 100/7: `done` in cycle 37 → quotient 14, remainder 2, `div_by_zero` 0. Also check `busy` high for exactly cycles 1–36.
- Unsigned 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0. Exercises the msb/CARRY_OUT accept path.
- Signed −7/2, i.e. 0xFFFFFFF9 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Signed −5/0 → quotient 0xFFFFFFFF, remainder 0xFFFFFFFB, `div_by_zero` 1. Unsigned 5/0 → quotient 0xFFFFFFFF, remainder 5, `div_by_zero` 1.
- Control and reset:
  - `start` again at cycle 10 with other operands → ignored, and the first result is unchanged.
  - `start` in the done cycle → second `done` exactly 37 cycles later.
  - `rst` at cycle 20 → `busy`=0 and all outputs 0 next cycle, with no `done` pulse.
